// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
// Contents:
//   SEG_OFF       - all segments dark (segments are active-low, bit order a..g, a is the MSB)
//   scan_state_e  - scanner state encoding (ST_BLANK, ST_DRIVE)
//   HEX_SEG_TABLE - hex digit to active-low segment pattern (a..g)
//   clog2         - ceiling log2 helper for sizing counters and indices
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Standard hex glyphs, active-low, MSB = segment a, LSB = segment g.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7.sv
// 4-bit hex to 7-segment decoder (active-low segments, a..g).
// Ports:
//   hex_i [3:0] - hex digit value
//   seg_o [6:0] - segment pattern, bit 6 = a ... bit 0 = g, 0 = lit
module display_scan_ctrl_seg7
    import display_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[hex_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed hex display scanner.
// Drives N_DIGITS hex digits through one shared 7-segment decoder onto a common
// segment bus, with a dead-time gap (all digits off) before every digit slot.
// New digit values are committed only at frame boundaries so a frame never
// mixes old and new digits.
//
// Ports:
//   clock       - system clock, rising edge
//   resetn      - asynchronous active-low reset
//   en          - scan enable; low blanks outputs and restarts the scan at digit 0
//   load        - capture strobe for digits_in
//   digits_in   - digit i in bits [4i+3:4i], digit 0 least significant
//   blank_mask  - bit i = 1 suppresses digit i
//   display     - segments a..g, active-low
//   digit_en    - active-low digit enables, at most one low
//   frame_done  - one-cycle pulse on the first cycle of each new frame
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, zero digits above the most significant nonzero digit are
//   blanked (digit 0 always shows). When undefined, zeros display normally.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DWELL    = 50000,
    parameter int DEAD     = 64
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic [0:6]            display,
    output logic [N_DIGITS-1:0]   digit_en,
    output logic                  frame_done
);

    localparam int CNT_MAX = (DWELL > DEAD) ? DWELL : DEAD;
    localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
    localparam int IDX_W   = clog2(N_DIGITS);

    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]    DEAD_LAST  = CNT_W'(DEAD - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] EN_ONE     = N_DIGITS'(1);

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    restart_q, restart_d;
    logic [4*N_DIGITS-1:0]   active_q, active_d;
    logic [4*N_DIGITS-1:0]   pending_q, pending_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [N_DIGITS-1:0]     digit_en_q, digit_en_d;
    logic [0:6]              display_q, display_d;
    logic                    frame_done_q, frame_done_d;

    logic                    frame_end_s;
    logic                    commit_s;
    logic [3:0]              digit_arr_s [N_DIGITS];
    logic [3:0]              digit_sel_s;
    logic [6:0]              seg_s;
    logic [N_DIGITS-1:0]     lz_mask_s;
    logic                    blank_s;

    // Last DRIVE cycle of the final digit closes the frame.
    assign frame_end_s = en && (state_q == ST_DRIVE) && (idx_q == IDX_LAST)
                         && (cnt_q == DWELL_LAST);
    // Commit happens at a frame end, or on the first enabled cycle after a pause.
    assign commit_s    = frame_end_s || (en && restart_q);

    // Scan sequencer: state, digit index and dwell/dead-time counter.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        restart_d = restart_q;
        if (!en) begin
            state_d   = ST_BLANK;
            idx_d     = '0;
            cnt_d     = '0;
            restart_d = 1'b1;
        end else begin
            restart_d = 1'b0;
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Digit value staging: loads park in pending, commits move them to active.
    always_comb begin
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        if (commit_s) begin
            // A load on the commit cycle itself wins over the older pending value.
            if (load) begin
                active_d = digits_in;
            end else if (pend_valid_q) begin
                active_d = pending_q;
            end else begin
                active_d = active_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pending_d    = digits_in;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit_split
        assign digit_arr_s[g] = active_d[4*g +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Suppress zero digits from the top down until the first nonzero digit.
    always_comb begin
        logic lz_run;
        lz_mask_s = '0;
        lz_run    = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (active_d[4*i +: 4] == 4'h0)) begin
                lz_mask_s[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end
`else
    assign lz_mask_s = '0;
`endif

    assign digit_sel_s = digit_arr_s[idx_d];

    display_scan_ctrl_seg7 u_seg7 (
        .hex_i (digit_sel_s),
        .seg_o (seg_s)
    );

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        blank_s = blank_mask[idx_d] | lz_mask_s[idx_d];
        if ((state_d == ST_DRIVE) && !blank_s) begin
            digit_en_d = ~(EN_ONE << idx_d);
            display_d  = seg_s;
        end else begin
            digit_en_d = '1;
            display_d  = SEG_OFF;
        end
        frame_done_d = frame_end_s;
    end

    // State, staging and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            restart_q    <= 1'b0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            digit_en_q   <= '1;
            display_q    <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            restart_q    <= restart_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            digit_en_q   <= digit_en_d;
            display_q    <= display_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign display    = display_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (N_DIGITS=4, DWELL=4, DEAD=2).
// A position-in-frame model predicts every output each cycle; directed
// sections pin the model with hand-derived literal values.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int DWELL = 4;
    localparam int DEAD  = 2;
    localparam int SLOT  = DEAD + DWELL;
    localparam int FRAME = N * SLOT;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [3:0] EN_LIT   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [6:0] SEG_12AF [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};

    logic        clock;
    logic        resetn;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;
    logic [0:6]  display;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    int          m_pos;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    bit          m_pv;
    bit          m_restart;
    logic [3:0]  exp_en;
    logic [6:0]  exp_disp;
    logic        exp_fd;

    display_scan_ctrl #(
        .N_DIGITS (N),
        .DWELL    (DWELL),
        .DEAD     (DEAD)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .blank_mask (blank_mask),
        .display    (display),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit lz_blank(input logic [15:0] v, input int s);
        bit r;
        r = (s > 0) && ((v >> (4 * s)) == 16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
        return r;
`else
        return r && 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pos     = 0;
        m_act     = 16'h0000;
        m_pend    = 16'h0000;
        m_pv      = 1'b0;
        m_restart = 1'b0;
        exp_en    = 4'b1111;
        exp_disp  = SEG_OFF;
        exp_fd    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit         boundary;
        int         slot;
        int         phase;
        logic [3:0] dig;
        if (!resetn) begin
            model_reset();
            return;
        end
        if (!en) begin
            if (load) begin
                m_pend = digits_in;
                m_pv   = 1'b1;
            end
            m_pos     = 0;
            m_restart = 1'b1;
            exp_fd    = 1'b0;
        end else begin
            boundary = (m_pos == FRAME - 1);
            if (boundary || m_restart) begin
                if (load) m_act = digits_in;
                else if (m_pv) m_act = m_pend;
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = digits_in;
                m_pv   = 1'b1;
            end
            exp_fd    = boundary;
            m_restart = 1'b0;
            m_pos     = (m_pos + 1) % FRAME;
        end
        slot  = m_pos / SLOT;
        phase = m_pos % SLOT;
        dig   = m_act[4*slot +: 4];
        if (phase >= DEAD && !blank_mask[slot] && !lz_blank(m_act, slot)) begin
            exp_en       = 4'b1111;
            exp_en[slot] = 1'b0;
            exp_disp     = GLYPH[dig];
        end else begin
            exp_en   = 4'b1111;
            exp_disp = SEG_OFF;
        end
    endtask

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_digit_en", 32'(digit_en), 32'(exp_en));
            check("cyc_display", 32'(display), 32'(exp_disp));
            check("cyc_frame_done", 32'(frame_done), 32'(exp_fd));
            check("cyc_one_hot_low", 32'($countones(~digit_en) <= 1), 32'd1);
        end
    end

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] en_x, input logic [6:0] seg_x);
        check({tag, "_en"}, 32'(digit_en), 32'(en_x));
        check({tag, "_seg"}, 32'(display), 32'(seg_x));
    endtask

    task automatic wait_frame_done(input string tag);
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < 200) begin
            cycle();
            k++;
        end
        check({tag, "_timeout"}, 32'(frame_done === 1'b1), 32'd1);
    endtask

    initial begin
        int pulses;
        int last;
        int slot;
        int phase;
        resetn     = 1'b1;
        en         = 1'b0;
        load       = 1'b0;
        digits_in  = 16'h0000;
        blank_mask = 4'b0000;
        model_reset();
        #2 resetn = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset state
        cycle();
        cycle();
        expect_out("reset", 4'b1111, SEG_OFF);
        check("reset_frame_done", 32'(frame_done), 32'd0);

        // Release: two blank cycles then digit 0 showing 0
        resetn = 1'b1;
        en     = 1'b1;
        cycle();
        expect_out("release_blank", 4'b1111, SEG_OFF);
        cycle();
        expect_out("release_drive", 4'b1110, 7'b0000001);

        // Asynchronous reset mid-DRIVE
        @(posedge clock);
        model_step();
        #2 resetn = 1'b0;
        #1;
        expect_out("async_reset", 4'b1111, SEG_OFF);
        model_reset();
        @(negedge clock);
        cycle();
        cycle();
        resetn = 1'b1;
        cycle();
        expect_out("rerelease_blank", 4'b1111, SEG_OFF);
        cycle();
        expect_out("rerelease_drive", 4'b1110, 7'b0000001);

        // Scan order with 12AF
        load      = 1'b1;
        digits_in = 16'h12AF;
        cycle();
        load = 1'b0;
        wait_frame_done("scan_wait");
        for (int c = 0; c < FRAME; c++) begin
            slot  = c / SLOT;
            phase = c % SLOT;
            if (phase < DEAD) expect_out("scan_dead", 4'b1111, SEG_OFF);
            else expect_out("scan_drive", EN_LIT[slot], SEG_12AF[slot]);
            cycle();
        end
        check("scan_frame_done_wrap", 32'(frame_done), 32'd1);

        // Frame pulse spacing over three frames
        pulses = 0;
        last   = 0;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            cycle();
            if (frame_done === 1'b1) begin
                pulses++;
                check("frame_gap", 32'(k - last), 32'd24);
                last = k;
            end
        end
        check("frame_pulses", 32'(pulses), 32'd3);

        // Tear-free update: load 0000 during digit 1 slot
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c == 8) begin
                load      = 1'b1;
                digits_in = 16'h0000;
            end else begin
                load = 1'b0;
            end
            if (c == 16) expect_out("tear_d2", 4'b1011, 7'b0010010);
            if (c == 22) expect_out("tear_d3", 4'b0111, 7'b1001111);
            if (c == 26) expect_out("new_d0", 4'b1110, 7'b0000001);
`ifdef LEADING_ZERO_BLANK_EN
            if (c == 32 || c == 38 || c == 44) expect_out("new_lz", 4'b1111, SEG_OFF);
`else
            if (c == 32) expect_out("new_d1", 4'b1101, 7'b0000001);
            if (c == 38) expect_out("new_d2", 4'b1011, 7'b0000001);
            if (c == 44) expect_out("new_d3", 4'b0111, 7'b0000001);
`endif
            cycle();
        end

        // Blank mask on digit 2
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c == 0) begin
                load       = 1'b1;
                digits_in  = 16'h12AF;
                blank_mask = 4'b0100;
            end else begin
                load = 1'b0;
            end
            if (c >= FRAME + 12 && c < FRAME + 18) expect_out("mask_d2", 4'b1111, SEG_OFF);
            if (c == FRAME + 2) expect_out("mask_d0", 4'b1110, 7'b0111000);
            if (c == FRAME + 20) expect_out("mask_d3", 4'b0111, 7'b1001111);
            cycle();
        end
        blank_mask = 4'b0000;

        // Enable drop mid-slot, load while paused, then restart
        cycle();
        cycle();
        cycle();
        en        = 1'b0;
        load      = 1'b1;
        digits_in = 16'h3456;
        cycle();
        load = 1'b0;
        expect_out("en_off", 4'b1111, SEG_OFF);
        check("en_off_fd", 32'(frame_done), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        en = 1'b1;
        cycle();
        expect_out("restart_blank", 4'b1111, SEG_OFF);
        cycle();
        expect_out("restart_d0", 4'b1110, 7'b0100000);

        // Leading zero handling with 0070
        load      = 1'b1;
        digits_in = 16'h0070;
        cycle();
        load = 1'b0;
        wait_frame_done("lz_wait");
        for (int c = 0; c < FRAME; c++) begin
            if (c == 2) expect_out("lz_d0", 4'b1110, 7'b0000001);
            if (c == 8) expect_out("lz_d1", 4'b1101, 7'b0001111);
`ifdef LEADING_ZERO_BLANK_EN
            if (c == 14) expect_out("lz_d2", 4'b1111, SEG_OFF);
            if (c == 20) expect_out("lz_d3", 4'b1111, SEG_OFF);
`else
            if (c == 14) expect_out("lz_d2", 4'b1011, 7'b0000001);
            if (c == 20) expect_out("lz_d3", 4'b0111, 7'b0000001);
`endif
            cycle();
        end

        // Randomized traffic checked by the model
        for (int k = 0; k < 1500; k++) begin
            en   = ($urandom_range(0, 19) != 0);
            load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) digits_in = 16'($urandom);
            else digits_in = 16'($urandom) & 16'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) blank_mask = 4'($urandom);
            cycle();
        end

        en   = 1'b1;
        load = 1'b0;
        cycle();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
